mem_rd_arbiter: RTL

- Shares the single burst read port toward the AXI bridge between two cache refill requesters: port 0 is the instruction cache refill, port 1 is the data cache refill.
- Grants one requester at a time with round-robin priority, forwards the read address, then steers the returned burst beats to the granted port.
- Port 0 can abort on pipeline flush; the in-flight burst is then drained and discarded.
- Sits between the cache refill masters and the external read channel.

---
 rtl/mem_rd_arbiter_pkg.sv | 15 +
 rtl/mem_rd_arbiter_if.sv | 24 ++
 rtl/mem_rd_arbiter_rr_arb2.sv | 16 +
 rtl/mem_rd_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_rd_arbiter_pkg.sv
// Shared constants and types for the two-port burst read arbiter.
package mem_rd_arbiter_pkg;

   localparam logic RST_ENABLE = 1'b1;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } state_t;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Burst read channel: address request plus returned beats.
interface mem_rd_arbiter_if #(
   parameter int ADDR_W = 32
) ();

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] rdata;
   logic              rvalid;
   logic              rlast;
   logic              rready;

   modport master (
      output araddr, arvalid, rready,
      input  arready, rdata, rvalid, rlast
   );

   modport slave (
      input  araddr, arvalid, rready,
      output arready, rdata, rvalid, rlast
   );

endinterface

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick; on a tie the port that was not served last wins.
module mem_rd_arbiter_rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic [1:0] gnt
);

   always_comb begin
      if (req == 2'b11) begin
         gnt = rr_last ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one burst read port between the I-cache (port 0) and D-cache (port 1)
// refill engines; a flushed port-0 burst is drained and discarded.
module mem_rd_arbiter
   import mem_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int P0_BURST_LEN = 8,
   parameter int P1_BURST_LEN = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_rd_arbiter_if.slave        s0,
   input  logic                   s0_flush,
   mem_rd_arbiter_if.slave        s1,
   mem_rd_arbiter_if.master       m,
   output logic [7:0]             m_arlen,
   output logic                   err
);

   localparam logic [7:0] P0_ARLEN = 8'(P0_BURST_LEN - 1);
   localparam logic [7:0] P1_ARLEN = 8'(P1_BURST_LEN - 1);

   state_t            state, state_nxt;
   logic              grant;
   logic              rr_last;
   logic              drain;
   logic [7:0]        beat_cnt;
   logic [ADDR_W-1:0] araddr_q;
   logic              arvalid_q;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              rready_c;
   logic              r_beat;
   logic              flush_hit;

   assign req       = {s1.arvalid, s0.arvalid & ~s0_flush};
   assign flush_hit = s0_flush && (grant == PORT0);
   assign rready_c  = (state == ST_R) && (drain || ((grant == PORT0) ? s0.rready : s1.rready));
   assign r_beat    = m.rvalid && rready_c;

   assign m.araddr  = araddr_q;
   assign m.arvalid = arvalid_q;
   assign m.rready  = rready_c;

   mem_rd_arbiter_rr_arb2 u_rr_arb2 (
      .req     (req),
      .rr_last (rr_last),
      .gnt     (gnt)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (|gnt)               state_nxt = ST_AR;
         ST_AR:   if (m.arready)          state_nxt = ST_R;
         ST_R:    if (r_beat && m.rlast)  state_nxt = ST_IDLE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      s0.arready = 1'b0;
      s0.rvalid  = 1'b0;
      s0.rdata   = '0;
      s0.rlast   = 1'b0;
      s1.arready = 1'b0;
      s1.rvalid  = 1'b0;
      s1.rdata   = '0;
      s1.rlast   = 1'b0;
      if (state == ST_AR) begin
         // A flushed port-0 address still completes downstream but is hidden from the cache.
         s0.arready = m.arready && (grant == PORT0) && !drain && !s0_flush;
         s1.arready = m.arready && (grant == PORT1);
      end
      if (state == ST_R) begin
         if (grant == PORT0) begin
            s0.rvalid = m.rvalid && !drain;
            s0.rdata  = m.rdata;
            s0.rlast  = m.rlast;
         end else begin
            s1.rvalid = m.rvalid;
            s1.rdata  = m.rdata;
            s1.rlast  = m.rlast;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= ST_IDLE;
         grant     <= PORT0;
         rr_last   <= PORT1;
         drain     <= 1'b0;
         beat_cnt  <= '0;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         m_arlen   <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            ST_IDLE: begin
               if (|gnt) begin
                  grant     <= gnt[1];
                  araddr_q  <= gnt[1] ? s1.araddr : s0.araddr;
                  m_arlen   <= gnt[1] ? P1_ARLEN : P0_ARLEN;
                  arvalid_q <= 1'b1;
                  drain     <= 1'b0;
               end
            end
            ST_AR: begin
               if (flush_hit) drain <= 1'b1;
               if (m.arready) begin
                  arvalid_q <= 1'b0;
                  beat_cnt  <= '0;
               end
            end
            ST_R: begin
               if (flush_hit) drain <= 1'b1;
               if (r_beat) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (m.rlast) begin
                     // beat_cnt still holds the count of earlier beats, so a full burst shows m_arlen.
                     if (beat_cnt != m_arlen) err <= 1'b1;
                     rr_last <= grant;
                     drain   <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
